// File: rtl/branch_history_unit.sv
// branch_history_unit
// Speculative global branch history for the gshare predictor. Every predicted
// conditional branch gets a checkpoint slot. A misprediction restores the
// history from its slot and squashes younger slots. Resolved branches train the
// BHT in allocation order.

`ifndef BRANCH_HISTORY_TABLE_SIZE
`define BRANCH_HISTORY_TABLE_SIZE 16
`endif

module branch_history_unit #(
    parameter int unsigned DEPTH    = `BRANCH_HISTORY_TABLE_SIZE,
    parameter int unsigned NUM_CKPT = 8,
    localparam int unsigned L       = $clog2(DEPTH),
    localparam int unsigned T       = $clog2(NUM_CKPT)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pred_valid,
    input  logic         pred_taken,
    input  logic [L-1:0] pred_index,
    output logic         pred_ready,
    output logic [T-1:0] pred_tag,
    output logic [L-1:0] bhr,
    input  logic         resolve_valid,
    input  logic [T-1:0] resolve_tag,
    input  logic         resolve_taken,
    output logic         mispredict,
    output logic         upd_en,
    output logic         upd_taken,
    output logic [L-1:0] upd_index
);

    logic [T:0]   head_q, head_d, tail_q, tail_d;
    logic [T:0]   count;
    logic [L-1:0] bhr_q, bhr_d;

    logic         valid_q    [NUM_CKPT];
    logic         valid_d    [NUM_CKPT];
    logic         resolved_q [NUM_CKPT];
    logic         resolved_d [NUM_CKPT];
    logic         ptaken_q   [NUM_CKPT];
    logic         ptaken_d   [NUM_CKPT];
    logic         ataken_q   [NUM_CKPT];
    logic         ataken_d   [NUM_CKPT];
    logic [L-1:0] index_q    [NUM_CKPT];
    logic [L-1:0] index_d    [NUM_CKPT];
    logic [L-1:0] hist_q     [NUM_CKPT];
    logic [L-1:0] hist_d     [NUM_CKPT];

    logic         mispredict_q, mispredict_d;
    logic         upd_en_q, upd_en_d;
    logic         upd_taken_q, upd_taken_d;
    logic [L-1:0] upd_index_q, upd_index_d;

    logic         res_hit;
    logic         res_miss;
    logic [T-1:0] head_idx;
    logic [T-1:0] tail_idx;
    logic [T-1:0] res_age;
    logic [T-1:0] slot_age;

    assign count      = tail_q - head_q;
    assign pred_ready = (count != (T+1)'(NUM_CKPT));
    assign pred_tag   = tail_q[T-1:0];
    assign bhr        = bhr_q;
    assign mispredict = mispredict_q;
    assign upd_en     = upd_en_q;
    assign upd_taken  = upd_taken_q;
    assign upd_index  = upd_index_q;

    assign head_idx = head_q[T-1:0];
    assign tail_idx = tail_q[T-1:0];
    assign res_hit  = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];
    assign res_miss = res_hit && (resolve_taken != ptaken_q[resolve_tag]);
    assign res_age  = resolve_tag - head_idx;

    // Next-state: in-order retire, resolve/repair, and allocation.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        bhr_d        = bhr_q;
        valid_d      = valid_q;
        resolved_d   = resolved_q;
        ptaken_d     = ptaken_q;
        ataken_d     = ataken_q;
        index_d      = index_q;
        hist_d       = hist_q;
        mispredict_d = res_miss;
        upd_en_d     = 1'b0;
        upd_taken_d  = upd_taken_q;
        upd_index_d  = upd_index_q;
        slot_age     = '0;

        if (valid_q[head_idx] && resolved_q[head_idx]) begin
            upd_en_d          = 1'b1;
            upd_taken_d       = ataken_q[head_idx];
            upd_index_d       = index_q[head_idx];
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + (T+1)'(1);
        end

        if (res_hit) begin
            resolved_d[resolve_tag] = 1'b1;
            ataken_d[resolve_tag]   = resolve_taken;
        end

        if (res_miss) begin
            // A retiring head is always older than the resolved slot, so the
            // squash never touches it. Tail is rebuilt from head to keep the
            // wrap bit consistent.
            bhr_d  = {hist_q[resolve_tag][L-2:0], resolve_taken};
            tail_d = head_q + {1'b0, res_age} + (T+1)'(1);
            for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                slot_age = T'(i) - head_idx;
                if (slot_age > res_age) begin
                    valid_d[i] = 1'b0;
                end
            end
        end else if (pred_valid && pred_ready) begin
            valid_d[tail_idx]    = 1'b1;
            resolved_d[tail_idx] = 1'b0;
            ptaken_d[tail_idx]   = pred_taken;
            index_d[tail_idx]    = pred_index;
            hist_d[tail_idx]     = bhr_q;
            tail_d               = tail_q + (T+1)'(1);
            bhr_d                = {bhr_q[L-2:0], pred_taken};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            bhr_q        <= '0;
            mispredict_q <= 1'b0;
            upd_en_q     <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_index_q  <= '0;
            for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                valid_q[i]    <= 1'b0;
                resolved_q[i] <= 1'b0;
                ptaken_q[i]   <= 1'b0;
                ataken_q[i]   <= 1'b0;
                index_q[i]    <= '0;
                hist_q[i]     <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            bhr_q        <= bhr_d;
            mispredict_q <= mispredict_d;
            upd_en_q     <= upd_en_d;
            upd_taken_q  <= upd_taken_d;
            upd_index_q  <= upd_index_d;
            for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                valid_q[i]    <= valid_d[i];
                resolved_q[i] <= resolved_d[i];
                ptaken_q[i]   <= ptaken_d[i];
                ataken_q[i]   <= ataken_d[i];
                index_q[i]    <= index_d[i];
                hist_q[i]     <= hist_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_history_unit.sv
// Testbench for branch_history_unit (DEPTH=16, NUM_CKPT=4).
// Expected BHT updates are queued as resolves are issued. A monitor pops and
// compares each one whenever upd_en is seen.

module tb_branch_history_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       pred_valid;
    logic       pred_taken;
    logic [3:0] pred_index;
    logic       pred_ready;
    logic [1:0] pred_tag;
    logic [3:0] bhr;
    logic       resolve_valid;
    logic [1:0] resolve_tag;
    logic       resolve_taken;
    logic       mispredict;
    logic       upd_en;
    logic       upd_taken;
    logic [3:0] upd_index;

    typedef struct packed {
        logic [3:0] idx;
        logic       tk;
    } upd_t;

    upd_t sb[$];
    upd_t mon_e;
    int   checks = 0;
    int   errors = 0;

    branch_history_unit #(
        .DEPTH    (16),
        .NUM_CKPT (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_index    (pred_index),
        .pred_ready    (pred_ready),
        .pred_tag      (pred_tag),
        .bhr           (bhr),
        .resolve_valid (resolve_valid),
        .resolve_tag   (resolve_tag),
        .resolve_taken (resolve_taken),
        .mispredict    (mispredict),
        .upd_en        (upd_en),
        .upd_taken     (upd_taken),
        .upd_index     (upd_index)
    );

    always #5 clock = ~clock;

    // Monitor: every upd_en pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && upd_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected: got index=%0h taken=%0b, expected no update",
                         upd_index, upd_taken);
            end else begin
                mon_e = sb.pop_front();
                if (upd_index !== mon_e.idx || upd_taken !== mon_e.tk) begin
                    errors++;
                    $display("FAIL upd: got index=%0h taken=%0b, expected index=%0h taken=%0b",
                             upd_index, upd_taken, mon_e.idx, mon_e.tk);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_upd(input logic [3:0] idx, input logic tk);
        upd_t e;
        e.idx = idx;
        e.tk  = tk;
        sb.push_back(e);
    endtask

    task automatic pred(input logic tk, input logic [3:0] idx, input logic [1:0] exp_tag,
                        input logic [3:0] exp_bhr);
        pred_valid = 1'b1;
        pred_taken = tk;
        pred_index = idx;
        chk("pred_tag", pred_tag, exp_tag);
        step();
        pred_valid = 1'b0;
        chk("bhr_after_pred", bhr, exp_bhr);
    endtask

    task automatic resolve(input logic [1:0] tag, input logic tk);
        resolve_valid = 1'b1;
        resolve_tag   = tag;
        resolve_taken = tk;
        step();
        resolve_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("drain_pending", sb.size(), 0);
        repeat (3) step();
    endtask

    task automatic do_reset();
        pred_valid    = 1'b0;
        pred_taken    = 1'b0;
        pred_index    = '0;
        resolve_valid = 1'b0;
        resolve_tag   = '0;
        resolve_taken = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_bhr", bhr, 0);
        chk("rst_ready", pred_ready, 1);
        chk("rst_tag", pred_tag, 0);
        chk("rst_upd_en", upd_en, 0);
        chk("rst_mispredict", mispredict, 0);
        step();
        step();
        chk("rst_upd_en_held", upd_en, 0);
        reset = 1'b1;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        step();

        // Reset and in-order training after correct resolves.
        do_reset();
        pred(1'b1, 4'd3, 2'd0, 4'b0001);
        pred(1'b0, 4'd5, 2'd1, 4'b0010);
        pred(1'b1, 4'd9, 2'd2, 4'b0101);
        expect_upd(4'd3, 1'b1);
        expect_upd(4'd5, 1'b0);
        resolve(2'd1, 1'b0);
        chk("s3_mispredict_a", mispredict, 0);
        resolve(2'd0, 1'b1);
        chk("s3_mispredict_b", mispredict, 0);
        chk("s3_bhr", bhr, 4'b0101);
        drain();
        expect_upd(4'd9, 1'b1);
        resolve(2'd2, 1'b1);
        drain();
        chk("s3_tag_end", pred_tag, 3);
        chk("s3_ready_end", pred_ready, 1);

        // Misprediction repair and squash.
        do_reset();
        pred(1'b1, 4'd3, 2'd0, 4'b0001);
        pred(1'b0, 4'd5, 2'd1, 4'b0010);
        pred(1'b1, 4'd9, 2'd2, 4'b0101);
        resolve(2'd1, 1'b1);
        chk("s4_bhr_repair", bhr, 4'b0011);
        chk("s4_mispredict", mispredict, 1);
        chk("s4_tag", pred_tag, 2);
        step();
        chk("s4_mispredict_pulse", mispredict, 0);
        resolve(2'd2, 1'b1);
        chk("s4_squashed_resolve_mp", mispredict, 0);
        chk("s4_squashed_resolve_bhr", bhr, 4'b0011);
        expect_upd(4'd3, 1'b1);
        expect_upd(4'd5, 1'b1);
        resolve(2'd0, 1'b1);
        drain();
        chk("s4_tag_end", pred_tag, 2);

        // Full ring, dropped prediction, and wrap of the tag.
        do_reset();
        pred(1'b1, 4'd1, 2'd0, 4'b0001);
        pred(1'b1, 4'd2, 2'd1, 4'b0011);
        pred(1'b0, 4'd4, 2'd2, 4'b0110);
        pred(1'b1, 4'd8, 2'd3, 4'b1101);
        chk("s5_full_ready", pred_ready, 0);
        pred_valid = 1'b1;
        pred_taken = 1'b1;
        pred_index = 4'd7;
        step();
        pred_valid = 1'b0;
        chk("s5_full_bhr", bhr, 4'b1101);
        chk("s5_full_ready_b", pred_ready, 0);
        expect_upd(4'd1, 1'b1);
        resolve(2'd0, 1'b1);
        chk("s5_ready_before_retire", pred_ready, 0);
        step();
        chk("s5_ready_after_retire", pred_ready, 1);
        chk("s5_tag_wrap", pred_tag, 0);
        drain();

        // Reset with resolved-but-blocked entries emits nothing.
        do_reset();
        pred(1'b1, 4'd1, 2'd0, 4'b0001);
        pred(1'b0, 4'd2, 2'd1, 4'b0010);
        pred(1'b1, 4'd3, 2'd2, 4'b0101);
        pred(1'b0, 4'd4, 2'd3, 4'b1010);
        resolve(2'd1, 1'b0);
        resolve(2'd2, 1'b1);
        resolve(2'd3, 1'b0);
        chk("s6_mispredict", mispredict, 0);
        do_reset();
        repeat (4) step();
        chk("s6_bhr", bhr, 0);
        chk("s6_ready", pred_ready, 1);
        chk("s6_tag", pred_tag, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
